// File: rtl/id_stage_hs.sv
// id_stage_hs: one-instruction decode stage between IF and EX.
// It has a valid/ready handshake on both sides and stalls on a load-use hazard.
// After a taken jump it squashes the next BR_SHADOW accepted instructions.
// ALU, register-file and memory controls for EX are decoded from the held instruction.
module id_stage_hs #(
   parameter int WIDTH         = 16,
   parameter int DATA_WIDTH    = 16,
   parameter int RF_WIDTH      = 3,
   parameter int OFF_WIDTH     = 6,
   parameter int ALU_CON_WIDTH = 3,
   parameter int BR_SHADOW     = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         instr_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         instr_reg,
   input  logic [DATA_WIDTH-1:0]    operand_a,
   input  logic                     ex_ld_valid,
   input  logic [RF_WIDTH-1:0]      ex_ld_addr,
   output logic [ALU_CON_WIDTH-1:0] alu_con,
   output logic                     rf_write_en,
   output logic                     mem_write_en,
   output logic                     operand_sel,
   output logic                     ld_sel,
   output logic [RF_WIDTH-1:0]      op1,
   output logic [RF_WIDTH-1:0]      op2,
   output logic [RF_WIDTH-1:0]      rf_write_addr,
   output logic [OFF_WIDTH-1:0]     offset,
   output logic                     jump
);

   typedef enum logic [0:0] {
      RUN    = 1'b0,
      SQUASH = 1'b1
   } state_t;

   localparam logic [2:0] SHADOW_INIT = 3'(BR_SHADOW);

   state_t                     state_r;
   state_t                     state_nx_s;
   logic [2:0]                 sq_cnt_r;
   logic [2:0]                 sq_cnt_nx_s;
   logic                       v_r;
   logic                       kill_r;

   logic [3:0]                 opcode_s;
   logic                       uses_op2_s;
   logic [ALU_CON_WIDTH-1:0]   alu_dec_s;
   logic                       rfw_dec_s;
   logic                       memw_dec_s;
   logic                       imm_dec_s;
   logic                       ld_dec_s;
   logic                       jmp_dec_s;
   logic                       hazard_s;
   logic                       live_s;
   logic                       fire_s;
   logic                       accept_s;

   // Instruction fields and register addresses
   assign opcode_s      = instr_reg[WIDTH-1 -: 4];
   assign op1           = instr_reg[6 +: RF_WIDTH];
   assign op2           = (opcode_s == 4'd11) ? instr_reg[9 +: RF_WIDTH] : instr_reg[3 +: RF_WIDTH];
   assign rf_write_addr = instr_reg[9 +: RF_WIDTH];
   assign offset        = instr_reg[OFF_WIDTH-1:0];

   // Opcode decode into the raw control bundle; qualification happens below
   always_comb begin
      uses_op2_s = 1'b0;
      alu_dec_s  = '0;
      rfw_dec_s  = 1'b0;
      memw_dec_s = 1'b0;
      imm_dec_s  = 1'b0;
      ld_dec_s   = 1'b0;
      jmp_dec_s  = 1'b0;
      case (opcode_s)
         4'd1: begin
            uses_op2_s = 1'b1;
            rfw_dec_s  = 1'b1;
         end
         4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
            uses_op2_s = 1'b1;
            rfw_dec_s  = 1'b1;
            alu_dec_s  = ALU_CON_WIDTH'(opcode_s - 4'd1);
         end
         4'd9: begin
            rfw_dec_s = 1'b1;
            imm_dec_s = 1'b1;
         end
         4'd10: begin
            rfw_dec_s = 1'b1;
            imm_dec_s = 1'b1;
            ld_dec_s  = 1'b1;
         end
         4'd11: begin
            uses_op2_s = 1'b1;
            memw_dec_s = 1'b1;
            imm_dec_s  = 1'b1;
         end
         4'd12: begin
            jmp_dec_s = (operand_a == {DATA_WIDTH{1'b0}});
         end
         4'd13: begin
            jmp_dec_s = 1'b1;
         end
         default: begin
            alu_dec_s = '0;
         end
      endcase
   end

   // Handshake: a killed instruction never stalls and never fires
   assign hazard_s  = v_r & ~kill_r & ex_ld_valid &
                      ((ex_ld_addr == op1) | ((ex_ld_addr == op2) & uses_op2_s));
   assign live_s    = v_r & ~kill_r & ~hazard_s;
   assign fire_s    = live_s & out_ready;
   assign in_ready  = ~v_r | kill_r | fire_s;
   assign accept_s  = in_valid & in_ready;
   assign out_valid = live_s;

   // Controls to EX; write enables only for a live instruction
   assign rf_write_en  = live_s & rfw_dec_s;
   assign mem_write_en = live_s & memw_dec_s;
   assign operand_sel  = v_r & imm_dec_s;
   assign ld_sel       = v_r & ld_dec_s;
   assign alu_con      = v_r ? alu_dec_s : {ALU_CON_WIDTH{1'b0}};
   assign jump         = fire_s & jmp_dec_s;

   // Holding register with its valid and squash flags
   always_ff @(posedge clk) begin
      if (!reset) begin
         instr_reg <= '0;
         v_r       <= 1'b0;
         kill_r    <= 1'b0;
      end else if (accept_s) begin
         instr_reg <= instr_in;
         v_r       <= 1'b1;
         kill_r    <= (state_r == SQUASH) | jump;
      end else if (kill_r | fire_s) begin
         v_r       <= 1'b0;
         kill_r    <= 1'b0;
      end
   end

   // Squash shadow: arm on a taken jump; each accept inside the shadow uses up one slot
   always_comb begin
      state_nx_s  = state_r;
      sq_cnt_nx_s = sq_cnt_r;
      case (state_r)
         RUN: begin
            if (jump) begin
               if (accept_s) begin
                  // The instruction accepted alongside the jump is the first shadow slot
                  sq_cnt_nx_s = SHADOW_INIT - 3'd1;
                  state_nx_s  = (SHADOW_INIT == 3'd1) ? RUN : SQUASH;
               end else begin
                  sq_cnt_nx_s = SHADOW_INIT;
                  state_nx_s  = SQUASH;
               end
            end else begin
               state_nx_s = RUN;
            end
         end
         SQUASH: begin
            if (accept_s) begin
               sq_cnt_nx_s = sq_cnt_r - 3'd1;
               if (sq_cnt_r == 3'd1) begin
                  state_nx_s = RUN;
               end else begin
                  state_nx_s = SQUASH;
               end
            end else begin
               state_nx_s = SQUASH;
            end
         end
         default: begin
            state_nx_s  = RUN;
            sq_cnt_nx_s = 3'd0;
         end
      endcase
   end

   // Squash state register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r  <= RUN;
         sq_cnt_r <= 3'd0;
      end else begin
         state_r  <= state_nx_s;
         sq_cnt_r <= sq_cnt_nx_s;
      end
   end

endmodule

// File: tb/tb_id_stage_hs.sv
// tb_id_stage_hs: scoreboard bench for id_stage_hs.
// operand_a is derived from the held instruction: bit0 == 0 gives zero, otherwise a nonzero value.
// A BEZ is therefore taken exactly when its bit0 is 0.
module tb_id_stage_hs;
   localparam int BR_SHADOW = 2;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, out_valid, out_ready, ex_ld_valid;
   logic        rf_write_en, mem_write_en, operand_sel, ld_sel, jump;
   logic [15:0] instr_in, instr_reg, operand_a;
   logic [2:0]  ex_ld_addr, alu_con, op1, op2, rf_write_addr;
   logic [5:0]  offset;

   always #5 clk = ~clk;

   assign operand_a = instr_reg[0] ? (16'h8000 | {10'h000, instr_reg[5:0]}) : 16'h0000;

   id_stage_hs #(.BR_SHADOW(BR_SHADOW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr_in(instr_in),
      .out_valid(out_valid), .out_ready(out_ready), .instr_reg(instr_reg), .operand_a(operand_a),
      .ex_ld_valid(ex_ld_valid), .ex_ld_addr(ex_ld_addr), .alu_con(alu_con),
      .rf_write_en(rf_write_en), .mem_write_en(mem_write_en), .operand_sel(operand_sel),
      .ld_sel(ld_sel), .op1(op1), .op2(op2), .rf_write_addr(rf_write_addr), .offset(offset),
      .jump(jump)
   );

   typedef struct packed {
      logic [15:0] instr;
      logic [2:0]  alu;
      logic        rfw;
      logic        memw;
      logic        osel;
      logic        lsel;
      logic        jmp;
      logic [2:0]  op1;
      logic [2:0]  op2;
      logic [2:0]  wa;
      logic [5:0]  off;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;
   int   sh_left = 0;
   int   fires = 0;
   int   jumps = 0;
   logic mon_en = 1'b0;
   logic rnd_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic uses_op2(input int opc);
      return ((opc >= 1) && (opc <= 8)) || (opc == 11);
   endfunction

   // Reference decode built directly from the opcode table
   function automatic exp_t model(input logic [15:0] ins);
      exp_t e;
      int   opc;
      opc    = int'(ins[15:12]);
      e.instr = ins;
      e.alu  = ((opc >= 2) && (opc <= 8)) ? 3'(opc - 1) : 3'd0;
      e.rfw  = (opc >= 1) && (opc <= 10);
      e.memw = (opc == 11);
      e.osel = (opc >= 9) && (opc <= 11);
      e.lsel = (opc == 10);
      e.jmp  = (opc == 13) || ((opc == 12) && (ins[0] == 1'b0));
      e.op1  = ins[8:6];
      e.op2  = (opc == 11) ? ins[11:9] : ins[5:3];
      e.wa   = ins[11:9];
      e.off  = ins[5:0];
      return e;
   endfunction

   // Each accepted instruction either falls in a jump shadow or is expected at EX
   task automatic note_accept(input logic [15:0] ins);
      exp_t e;
      if (sh_left > 0) begin
         sh_left--;
      end else begin
         e = model(ins);
         sb_q.push_back(e);
         if (e.jmp) sh_left = BR_SHADOW;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_en) begin
         out_ready   = ($urandom_range(0, 3) != 0);
         ex_ld_valid = ($urandom_range(0, 3) == 0);
         ex_ld_addr  = 3'($urandom);
      end
   endtask

   task automatic send(input logic [15:0] ins, output int waited);
      waited   = 0;
      in_valid = 1'b1;
      instr_in = ins;
      while (1) begin
         @(negedge clk);
         #1;
         if (in_ready === 1'b1) begin
            note_accept(ins);
            tick();
            in_valid = 1'b0;
            return;
         end
         tick();
         waited++;
         if (waited > 300) begin
            chk("accept_timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
            return;
         end
      end
   endtask

   // Monitor: whenever the stage presents an instruction, compare it with the scoreboard head
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (jump === 1'b1) jumps++;
            if (out_valid === 1'b1) begin
               if (sb_q.size() == 0) begin
                  chk("unexpected_valid", {31'd0, out_valid}, 32'd0);
               end else begin
                  mon_e = sb_q[0];
                  chk("instr", {16'd0, instr_reg}, {16'd0, mon_e.instr});
                  chk("ctrl", {24'd0, alu_con, rf_write_en, mem_write_en, operand_sel, ld_sel, jump},
                      {24'd0, mon_e.alu, mon_e.rfw, mon_e.memw, mon_e.osel, mon_e.lsel,
                       mon_e.jmp & out_ready});
                  chk("fields", {17'd0, op1, op2, rf_write_addr, offset},
                      {17'd0, mon_e.op1, mon_e.op2, mon_e.wa, mon_e.off});
                  if (out_ready === 1'b1) begin
                     fires++;
                     chk("fire_without_hazard",
                         {31'd0, ex_ld_valid & ((ex_ld_addr == mon_e.op1) |
                          ((ex_ld_addr == mon_e.op2) & uses_op2(int'(mon_e.instr[15:12]))))}, 32'd0);
                     void'(sb_q.pop_front());
                  end
               end
            end else begin
               chk("idle_ctrl", {29'd0, rf_write_en, mem_write_en, jump}, 32'd0);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int f0;
      int j0;
      reset = 1'b0; in_valid = 1'b1; instr_in = 16'h1A4C;
      out_ready = 1'b0; ex_ld_valid = 1'b0; ex_ld_addr = 3'd0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_jump", {31'd0, jump}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_instr_reg", {16'd0, instr_reg}, 32'd0);
      tick();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mon_en = 1'b1;

      // Back-to-back ADD, SUB
      f0 = fires;
      send(16'h1A4C, w);
      send(16'h2A4C, w);
      chk("stream_no_stall", w, 32'd0);
      @(negedge clk); #1;
      chk("stream_two_fires", fires, f0 + 2);
      tick();

      // Load-use on op1
      ex_ld_valid = 1'b1; ex_ld_addr = 3'd1;
      send(16'h1048, w);
      in_valid = 1'b1; instr_in = 16'h3000;
      repeat (3) begin
         @(negedge clk); #1;
         chk("lu_out_valid", {31'd0, out_valid}, 32'd0);
         chk("lu_in_ready", {31'd0, in_ready}, 32'd0);
         tick();
      end
      in_valid = 1'b0; ex_ld_valid = 1'b0; f0 = fires;
      @(negedge clk); #1;
      chk("lu_release_fire", fires, f0 + 1);
      tick();

      // Immediate op: matching [5:3] field is not a source, so no stall
      ex_ld_valid = 1'b1; ex_ld_addr = 3'd1;
      send(16'h9008, w);
      @(negedge clk); #1;
      chk("imm_no_stall", {31'd0, out_valid}, 32'd1);
      tick();

      // Store: op2 comes from [11:9]; then backpressure
      send(16'hB2C3, w);
      repeat (2) begin
         @(negedge clk); #1;
         chk("st_hazard", {31'd0, out_valid}, 32'd0);
         tick();
      end
      ex_ld_valid = 1'b0; out_ready = 1'b0;
      repeat (3) begin
         @(negedge clk); #1;
         chk("bp_mem_write_en", {31'd0, mem_write_en}, 32'd1);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         tick();
      end
      f0 = fires; out_ready = 1'b1;
      @(negedge clk); #1;
      chk("bp_one_fire", fires, f0 + 1);
      tick();
      @(negedge clk); #1;
      chk("bp_no_second_fire", fires, f0 + 1);
      tick();

      // BEZ taken: two squashed, third executes
      f0 = fires; j0 = jumps;
      send(16'hC040, w); send(16'h1A4C, w); send(16'h2A4C, w); send(16'h3A4C, w);
      repeat (2) tick();
      chk("bez_taken_jumps", jumps, j0 + 1);
      chk("bez_taken_fires", fires, f0 + 2);

      // BEZ not taken
      f0 = fires; j0 = jumps;
      send(16'hC041, w); send(16'h1A4C, w);
      repeat (2) tick();
      chk("bez_nt_jumps", jumps, j0);
      chk("bez_nt_fires", fires, f0 + 2);

      // Unconditional jump with nonzero operand_a
      f0 = fires; j0 = jumps;
      send(16'hD041, w); send(16'h4A4C, w); send(16'h5A4C, w); send(16'h6A4C, w);
      repeat (2) tick();
      chk("jmp_jumps", jumps, j0 + 1);
      chk("jmp_fires", fires, f0 + 2);

      // Reset while the shadow is still armed
      send(16'hD000, w); send(16'h1A4C, w);
      mon_en = 1'b0; reset = 1'b0; out_ready = 1'b0;
      tick();
      reset = 1'b1; out_ready = 1'b1;
      sb_q.delete(); sh_left = 0;
      @(negedge clk); #1;
      chk("rst_sq_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_sq_in_ready", {31'd0, in_ready}, 32'd1);
      mon_en = 1'b1;
      tick();
      f0 = fires;
      send(16'h7A4C, w);
      repeat (2) tick();
      chk("rst_sq_executes", fires, f0 + 1);

      // Randomized traffic with random backpressure and load hazards
      rnd_en = 1'b1;
      for (int i = 0; i < 300; i++) begin
         send(16'($urandom), w);
         repeat ($urandom_range(0, 1)) tick();
      end
      rnd_en = 1'b0; out_ready = 1'b1; ex_ld_valid = 1'b0;
      while (sh_left > 0) send(16'h0000, w);
      for (int k = 0; (k < 100) && (sb_q.size() > 0); k++) tick();
      chk("drain_empty", sb_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
